// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the count_ctrl run controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_PRE_WIDTH = 4;

endpackage

// File: rtl/count_ctrl_counter.sv
// WIDTH-bit up-counter: register plus incrementer, with synchronous clear and enable.
module count_ctrl_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/count_ctrl.sv
// Run controller driving an enabled up-counter to a programmed length.
// Optional tick prescaler is compiled in when COUNT_CTRL_PRESCALE_EN is defined.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_len,
  input  logic                 cmd_repeat,
  input  logic                 abort,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 tick_en,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] len_reg;
  logic             repeat_reg;
  logic             accept;
  logic             tick;
  logic             cnt_clr;
  logic             cnt_en;
  logic [WIDTH-1:0] count_inc;

  assign cmd_ready = !rst && (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign tick_en   = tick;
  assign count_inc = count + 1'b1;

`ifdef COUNT_CTRL_PRESCALE_EN
  logic [PRE_WIDTH-1:0] prescale_reg;
  logic [PRE_WIDTH-1:0] pre_cnt_reg;

  assign tick = (state_reg == RUN) && (pre_cnt_reg == prescale_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_reg <= '0;
      pre_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        prescale_reg <= prescale;
      end
      if (cnt_clr) begin
        pre_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
      end
    end
  end
`else
  // Without the prescaler every RUN cycle is a tick; the port stays for a stable interface.
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick = (state_reg == RUN);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      repeat_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        len_reg    <= cmd_len;
        repeat_reg <= cmd_repeat;
      end
    end
  end

  // Abort wins over completion and also freezes the counter on that edge.
  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_clr    = 1'b1;
          state_next = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick) begin
          cnt_en = 1'b1;
          if (count_inc == len_reg) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (repeat_reg) begin
          cnt_clr    = 1'b1;
          state_next = (len_reg == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  count_ctrl_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

endmodule

// File: tb/tb_count_ctrl.sv
// Directed self-checking bench for count_ctrl; prescaler case follows COUNT_CTRL_PRESCALE_EN.
module tb_count_ctrl;

  localparam int WIDTH     = 8;
  localparam int PRE_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_len;
  logic                 cmd_repeat;
  logic                 abort;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 tick_en;
  logic [WIDTH-1:0]     count;
  logic                 busy;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  count_ctrl #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_repeat (cmd_repeat),
    .abort      (abort),
    .prescale   (prescale),
    .tick_en    (tick_en),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 2ns after the next rising edge, where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [WIDTH-1:0] len, input logic rep, input logic [PRE_WIDTH-1:0] pre);
    cmd_valid  = 1'b1;
    cmd_len    = len;
    cmd_repeat = rep;
    prescale   = pre;
    step();
    cmd_valid  = 1'b0;
    $display("cmd len=%0d repeat=%0d prescale=%0d accepted busy=%0b count=%0d", len, rep, pre, busy, count);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_len    = 8'd5;
    cmd_repeat = 1'b0;
    abort      = 1'b0;
    prescale   = '0;

    // Reset held with cmd_valid high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", cmd_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1);
    $display("reset released cmd_ready=%0b", cmd_ready);

    // One-shot len=5
    issue(8'd5, 1'b0, 4'd0);
    chk("os_c0_count", count, 0);
    chk("os_c0_busy", busy, 1);
    chk("os_c0_done", done, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("os_count", count, k);
      chk("os_done", done, (k == 5) ? 1 : 0);
      chk("os_tick", tick_en, (k < 5) ? 1 : 0);
    end
    step();
    chk("os_c6_ready", cmd_ready, 1);
    chk("os_c6_count", count, 5);
    chk("os_c6_done", done, 0);

    // Repeat len=3, cmd_valid kept high with a different length
    issue(8'd3, 1'b1, 4'd0);
    cmd_valid = 1'b1;
    cmd_len   = 8'd7;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      chk("rep_count", count, c % 4);
      chk("rep_done", done, (c % 4 == 3) ? 1 : 0);
      chk("rep_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    chk("rep_abort_busy", busy, 0);
    chk("rep_abort_count", count, 3);
    $display("repeat run aborted in DONE count=%0d", count);

    // Zero length
    issue(8'd0, 1'b0, 4'd0);
    chk("z_c0_done", done, 1);
    chk("z_c0_count", count, 0);
    step();
    chk("z_c1_busy", busy, 0);
    chk("z_c1_done", done, 0);
    chk("z_c1_ready", cmd_ready, 1);

    // Abort at count=4 of len=10
    issue(8'd10, 1'b0, 4'd0);
    for (int k = 1; k <= 4; k++) step();
    chk("ab_pre_count", count, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_count", count, 4);
    chk("ab_done", done, 0);
    step();
    chk("ab_hold_count", count, 4);
    chk("ab_hold_done", done, 0);

    // Abort on the final RUN cycle beats completion
    issue(8'd3, 1'b0, 4'd0);
    step();
    step();
    chk("sim_pre_count", count, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("sim_done", done, 0);
    chk("sim_busy", busy, 0);
    chk("sim_count", count, 2);

    // cmd_valid offered during DONE is ignored
    issue(8'd2, 1'b0, 4'd0);
    step();
    step();
    chk("dv_done", done, 1);
    cmd_valid = 1'b1;
    cmd_len   = 8'd9;
    step();
    chk("dv_busy", busy, 0);
    chk("dv_count", count, 2);
    chk("dv_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    step();
    chk("dv_idle", busy, 0);

    // Reset in the middle of a run
    issue(8'd5, 1'b0, 4'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mr_busy", busy, 0);
    chk("mr_count", count, 0);
    chk("mr_done", done, 0);
    rst = 1'b0;
    step();

    // Prescaled run, len=2, prescale=2
    issue(8'd2, 1'b0, 4'd2);
`ifdef COUNT_CTRL_PRESCALE_EN
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      chk("pre_tick", tick_en, (c == 2 || c == 5) ? 1 : 0);
      chk("pre_done", done, (c == 6) ? 1 : 0);
    end
`else
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) step();
      chk("nopre_tick", tick_en, (c < 2) ? 1 : 0);
      chk("nopre_done", done, (c == 2) ? 1 : 0);
    end
`endif
    step();
    chk("pre_end_busy", busy, 0);
    chk("pre_end_count", count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
